// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard that stalls decode on RAW/WAW hazards.
// Optional HI/LO tracking is compiled in when HAZARD_SB_HILO_EN is defined.
module hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int NUM_REGS    = 32,
  parameter int LAT_W       = 3,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                hold_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   rs_d_i,
  input  logic                rs_used_i,
  input  logic [REG_AW-1:0]   rt_d_i,
  input  logic                rt_used_i,
  input  logic [REG_AW-1:0]   dst_d_i,
  input  logic                wr_d_i,
  input  logic [LAT_W-1:0]    lat_d_i,
`ifdef HAZARD_SB_HILO_EN
  input  logic                hilo_rd_d_i,
  input  logic                hilo_wr_d_i,
`endif
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [REG_AW:0]     pending_o,
  output logic [31:0]         perf_stall_cnt_o
);

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [REG_AW:0]     pending;
  logic [31:0]         perf_q, perf_d;
  logic                track_wr, advance, accept, hazard;

  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      pending = pending + (REG_AW+1)'(busy[i]);
    end
  end

  assign track_wr = wr_d_i & (lat_d_i != '0);
  assign advance  = ~hold_i & ~flush_i;

`ifdef HAZARD_SB_HILO_EN
  logic [LAT_W-1:0] hilo_cnt_q, hilo_cnt_d;
  logic             hilo_busy;

  assign hilo_busy = (hilo_cnt_q != '0);
`endif

  always_comb begin
    hazard = (rs_used_i & busy[rs_d_i])
           | (rt_used_i & busy[rt_d_i])
           | (track_wr & busy[dst_d_i])
           | (track_wr & (dst_d_i != '0) & (pending == (REG_AW+1)'(MAX_PENDING)));
`ifdef HAZARD_SB_HILO_EN
    hazard = hazard
           | (hilo_rd_d_i & hilo_busy)
           | (hilo_wr_d_i & (lat_d_i != '0) & hilo_busy);
`endif
  end

  assign stall_o = issue_valid_i & hazard;
  assign accept  = issue_valid_i & ~stall_o & advance & track_wr & (dst_d_i != '0);

  // Flush wins over everything; otherwise decrement all, then the accepted
  // destination (never busy, thanks to the WAW stall) is loaded fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
    end else if (advance) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
      if (accept) cnt_d[dst_d_i] = lat_d_i;
    end
    cnt_d[0] = '0;
  end

`ifdef HAZARD_SB_HILO_EN
  always_comb begin
    hilo_cnt_d = hilo_cnt_q;
    if (flush_i) begin
      hilo_cnt_d = '0;
    end else if (advance) begin
      if (hilo_busy) hilo_cnt_d = hilo_cnt_q - LAT_W'(1);
      if (accept && hilo_wr_d_i) hilo_cnt_d = lat_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) hilo_cnt_q <= '0;
    else         hilo_cnt_q <= hilo_cnt_d;
  end
`endif

  always_comb begin
    perf_d = perf_q;
    if (stall_o && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '{default: '0};
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign busy_o           = busy;
  assign pending_o        = pending;
  assign perf_stall_cnt_o = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        resetn, hold_i, flush_i, issue_valid_i;
  logic [4:0]  rs_d_i, rt_d_i, dst_d_i;
  logic        rs_used_i, rt_used_i, wr_d_i;
  logic [2:0]  lat_d_i;
  logic        stall_o;
  logic [31:0] busy_o;
  logic [5:0]  pending_o;
  logic [31:0] perf_stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW(5), .NUM_REGS(32), .LAT_W(3), .MAX_PENDING(4)
  ) dut (
    .clk(clk), .resetn(resetn), .hold_i(hold_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i),
    .rs_d_i(rs_d_i), .rs_used_i(rs_used_i),
    .rt_d_i(rt_d_i), .rt_used_i(rt_used_i),
    .dst_d_i(dst_d_i), .wr_d_i(wr_d_i), .lat_d_i(lat_d_i),
`ifdef HAZARD_SB_HILO_EN
    .hilo_rd_d_i(1'b0), .hilo_wr_d_i(1'b0),
`endif
    .stall_o(stall_o), .busy_o(busy_o), .pending_o(pending_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; rs_used_i = 0; rt_used_i = 0; wr_d_i = 0;
    rs_d_i = 0; rt_d_i = 0; dst_d_i = 0; lat_d_i = 0;
    hold_i = 0; flush_i = 0;
  endtask

  task automatic wr(input logic [4:0] dst, input logic [2:0] lat);
    idle();
    issue_valid_i = 1; wr_d_i = 1; dst_d_i = dst; lat_d_i = lat;
  endtask

  initial begin
    idle();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    repeat (5) tick();
    settle();
    chk("reset_busy",    busy_o, 32'h0);
    chk("reset_pending", 32'(pending_o), 32'd0);
    chk("reset_stall",   32'(stall_o), 32'd0);
    chk("reset_perf",    perf_stall_cnt_o, 32'd0);

    // Load-use, latency 1
    wr(5'd8, 3'd1); settle();
    chk("lu_issue_stall", 32'(stall_o), 32'd0);
    tick();
    idle(); issue_valid_i = 1; rs_d_i = 5'd8; rs_used_i = 1; settle();
    chk("lu_stall",   32'(stall_o), 32'd1);
    chk("lu_busy",    busy_o, 32'h0000_0100);
    chk("lu_pending", 32'(pending_o), 32'd1);
    tick(); settle();
    chk("lu_release", 32'(stall_o), 32'd0);
    chk("lu_perf",    perf_stall_cnt_o, 32'd1);
    tick();

    // Mul, latency 3
    wr(5'd9, 3'd3); tick();
    idle(); issue_valid_i = 1; rt_d_i = 5'd9; rt_used_i = 1; settle();
    chk("mul_stall_c1", 32'(stall_o), 32'd1);
    tick(); settle();
    chk("mul_stall_c2", 32'(stall_o), 32'd1);
    tick(); settle();
    chk("mul_stall_c3", 32'(stall_o), 32'd1);
    tick(); settle();
    chk("mul_release", 32'(stall_o), 32'd0);
    chk("mul_busy9",   32'(busy_o[9]), 32'd0);
    chk("mul_perf",    perf_stall_cnt_o, 32'd4);
    tick();

    // Hold while cnt[9]=2
    wr(5'd9, 3'd3); tick();
    idle(); issue_valid_i = 1; rt_d_i = 5'd9; rt_used_i = 1;
    tick();
    hold_i = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("hold_stall", 32'(stall_o), 32'd1);
      tick();
    end
    settle();
    chk("hold_frozen_busy", 32'(busy_o[9]), 32'd1);
    hold_i = 0; settle();
    chk("hold_after_c1", 32'(stall_o), 32'd1);
    tick(); settle();
    chk("hold_after_c2", 32'(stall_o), 32'd1);
    tick(); settle();
    chk("hold_release", 32'(stall_o), 32'd0);
    chk("hold_perf",    perf_stall_cnt_o, 32'd11);
    tick();

    // MAX_PENDING
    wr(5'd1, 3'd7); tick();
    wr(5'd2, 3'd7); tick();
    wr(5'd3, 3'd7); tick();
    wr(5'd4, 3'd7); tick();
    wr(5'd5, 3'd7); settle();
    chk("full_stall",   32'(stall_o), 32'd1);
    chk("full_pending", 32'(pending_o), 32'd4);
    lat_d_i = 3'd0; settle();
    chk("full_lat0_stall", 32'(stall_o), 32'd0);
    tick(); settle();
    chk("full_busy", busy_o, 32'h0000_001E);
    chk("full_perf", perf_stall_cnt_o, 32'd11);

    // Flush clears everything
    idle(); flush_i = 1; tick();
    idle(); settle();
    chk("flush1_busy",    busy_o, 32'h0);
    chk("flush1_pending", 32'(pending_o), 32'd0);
    wr(5'd3, 3'd5); tick();
    wr(5'd4, 3'd5); tick();
    idle(); settle();
    chk("pre_flush_busy", busy_o, 32'h0000_0018);
    wr(5'd6, 3'd2); flush_i = 1; settle();
    chk("flush_stall_indep", 32'(stall_o), 32'd0);
    tick();
    idle(); settle();
    chk("flush2_busy",    busy_o, 32'h0);
    chk("flush2_pending", 32'(pending_o), 32'd0);

    // Register 0 is never tracked
    wr(5'd0, 3'd5); tick();
    idle(); settle();
    chk("r0_busy", busy_o, 32'h0);

    // WAW
    wr(5'd7, 3'd2); tick();
    wr(5'd7, 3'd3); settle();
    chk("waw_stall", 32'(stall_o), 32'd1);
    lat_d_i = 3'd0; settle();
    chk("waw_lat0", 32'(stall_o), 32'd0);
    idle(); settle();
    chk("no_issue_stall", 32'(stall_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
